// File: rtl/divisor_multicanal.sv
// -----------------------------------------------------------------------------
// divisor_multicanal
//
// Purpose
//   N_CH independent programmable clock dividers sharing one clock, one
//   restart pulse and one configuration write port. Each channel counts
//   0..per_act and drives a registered divided clock that is high while
//   the count is below hi_act, plus a one-cycle tick on every period wrap.
//
//   Each channel keeps a shadow (per_sh, hi_sh) pair written by the config
//   port and an active (per_act, hi_act) pair that the counter uses. The
//   active pair only reloads at a wrap, on sync, or while the channel is
//   disabled, so a period in progress is never disturbed by a write.
//
// Ports
//   clk       in   single clock, all logic on the rising edge
//   reset     in   synchronous, active-high; overrides every other input
//   en        in   [N_CH]   per-channel run enable
//   sync      in   one-cycle pulse, restarts all enabled channels in phase
//   cfg_we    in   configuration write strobe, one cycle per write
//   cfg_ch    in   [3]      target channel (values >= N_CH are ignored)
//   cfg_sel   in   0 = period register, 1 = high-time register
//   cfg_data  in   [CNT_W]  value written
//   out_clk   out  [N_CH]   registered divided clock per channel
//   tick      out  [N_CH]   registered one-cycle pulse per period wrap
//
// Config port handshake: cfg_we acts as a valid with an implicit, always
// asserted ready. Every cycle with cfg_we=1 is exactly one accepted write;
// there is no back-pressure and no ready output.
// -----------------------------------------------------------------------------
module divisor_multicanal #(
  parameter int          N_CH    = 2,
  parameter int          CNT_W   = 26,
  parameter int unsigned PER_DEF = 24999999,
  parameter int unsigned HI_DEF  = 12500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  en,
  input  logic             sync,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_ch,
  input  logic             cfg_sel,
  input  logic [CNT_W-1:0] cfg_data,
  output logic [N_CH-1:0]  out_clk,
  output logic [N_CH-1:0]  tick
);

  localparam logic [CNT_W-1:0] PER_RST = CNT_W'(PER_DEF);
  localparam logic [CNT_W-1:0] HI_RST  = CNT_W'(HI_DEF);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] per_sh;
    logic [CNT_W-1:0] hi_sh;
    logic [CNT_W-1:0] per_act;
    logic [CNT_W-1:0] hi_act;
    logic             out_r;
    logic             tick_r;
    logic             wr_hit;
    logic             at_wrap;

    // cfg_ch is compared on all three bits, so channel numbers >= N_CH
    // simply never match any channel.
    assign wr_hit  = cfg_we && (cfg_ch == 3'(i));
    assign at_wrap = (cnt == per_act);

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt     <= '0;
        per_sh  <= PER_RST;
        hi_sh   <= HI_RST;
        per_act <= PER_RST;
        hi_act  <= HI_RST;
        out_r   <= 1'b0;
        tick_r  <= 1'b0;
      end else begin
        // Shadow write. The active reloads below read the register's
        // current (pre-write) value, so a write landing on a wrap or sync
        // cycle only takes effect at the following wrap.
        if (wr_hit) begin
          if (cfg_sel) hi_sh  <= cfg_data;
          else         per_sh <= cfg_data;
        end

        if (!en[i]) begin
          cnt     <= '0;
          per_act <= per_sh;
          hi_act  <= hi_sh;
          out_r   <= 1'b0;
          tick_r  <= 1'b0;
        end else begin
          // Compare uses this cycle's count and high time; the flop gives
          // one clock of latency and a glitch-free output.
          out_r <= (cnt < hi_act);
          if (sync) begin
            // sync wins over a coincident wrap: restart without a tick.
            cnt     <= '0;
            per_act <= per_sh;
            hi_act  <= hi_sh;
            tick_r  <= 1'b0;
          end else if (at_wrap) begin
            cnt     <= '0;
            per_act <= per_sh;
            hi_act  <= hi_sh;
            tick_r  <= 1'b1;
          end else begin
            cnt    <= cnt + CNT_W'(1);
            tick_r <= 1'b0;
          end
        end
      end
    end

    assign out_clk[i] = out_r;
    assign tick[i]    = tick_r;
  end

endmodule

// File: tb/tb_divisor_multicanal.sv
// -----------------------------------------------------------------------------
// tb_divisor_multicanal
//
// Bench for divisor_multicanal with CNT_W=8, PER_DEF=9, HI_DEF=5, N_CH=2.
// A reference model derived from the channel rules predicts {out_clk, tick}
// for every clock; predictions go through an expected queue and are compared
// one cycle later. A vector table covers the first cycles after reset and
// hand-written sequences cover period change, high-time zero, sync, reset
// during a write, per=0 and an out-of-range channel write. A random phase
// follows.
// -----------------------------------------------------------------------------
module tb_divisor_multicanal;

  localparam int N_CH    = 2;
  localparam int CNT_W   = 8;
  localparam int PER_DEF = 9;
  localparam int HI_DEF  = 5;

  // ---------------------------------------------------------------- clock/reset
  logic             clk      = 1'b0;
  logic             reset    = 1'b1;
  logic [N_CH-1:0]  en       = '0;
  logic             sync     = 1'b0;
  logic             cfg_we   = 1'b0;
  logic [2:0]       cfg_ch   = '0;
  logic             cfg_sel  = 1'b0;
  logic [CNT_W-1:0] cfg_data = '0;
  logic [N_CH-1:0]  out_clk;
  logic [N_CH-1:0]  tick;

  always #5 clk = ~clk;

  divisor_multicanal #(
    .N_CH   (N_CH),
    .CNT_W  (CNT_W),
    .PER_DEF(PER_DEF),
    .HI_DEF (HI_DEF)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .sync    (sync),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_sel (cfg_sel),
    .cfg_data(cfg_data),
    .out_clk (out_clk),
    .tick    (tick)
  );

  // ---------------------------------------------------------------- bookkeeping
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  // Per channel: position within the current period plus shadow/active pairs.
  int          m_pos   [N_CH];
  int          m_per_sh[N_CH];
  int          m_hi_sh [N_CH];
  int          m_per   [N_CH];
  int          m_hi    [N_CH];
  logic [N_CH-1:0] m_out;
  logic [N_CH-1:0] m_tick;

  logic [2*N_CH-1:0] exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_pos[i]    = 0;
      m_per_sh[i] = PER_DEF;
      m_hi_sh[i]  = HI_DEF;
      m_per[i]    = PER_DEF;
      m_hi[i]     = HI_DEF;
      m_out[i]    = 1'b0;
      m_tick[i]   = 1'b0;
    end
  endtask

  // Predicts the outputs after the coming edge from the inputs now applied.
  task automatic model_step();
    int old_per;
    int old_hi;
    if (reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        old_per = m_per_sh[i];
        old_hi  = m_hi_sh[i];
        if (cfg_we && (int'(cfg_ch) == i)) begin
          if (cfg_sel) m_hi_sh[i]  = int'(cfg_data);
          else         m_per_sh[i] = int'(cfg_data);
        end
        if (!en[i]) begin
          m_pos[i]  = 0;
          m_per[i]  = old_per;
          m_hi[i]   = old_hi;
          m_out[i]  = 1'b0;
          m_tick[i] = 1'b0;
        end else begin
          m_out[i] = (m_pos[i] < m_hi[i]);
          if (sync || (m_pos[i] == m_per[i])) begin
            m_tick[i] = !sync;
            m_pos[i]  = 0;
            m_per[i]  = old_per;
            m_hi[i]   = old_hi;
          end else begin
            m_tick[i] = 1'b0;
            m_pos[i]  = m_pos[i] + 1;
          end
        end
      end
    end
    exp_q.push_back({m_out, m_tick});
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic drive(input logic r, input logic [N_CH-1:0] e, input logic s,
                       input logic w, input logic [2:0] c, input logic sl,
                       input logic [CNT_W-1:0] d);
    logic [2*N_CH-1:0] exp_v;
    @(negedge clk);
    reset    = r;
    en       = e;
    sync     = s;
    cfg_we   = w;
    cfg_ch   = c;
    cfg_sel  = sl;
    cfg_data = d;
    model_step();
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    check("scoreboard", {out_clk, tick}, exp_v);
  endtask

  task automatic idle();
    drive(1'b0, 2'b11, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0);
  endtask

  task automatic wr(input logic [2:0] c, input logic sl, input logic [CNT_W-1:0] d);
    drive(1'b0, 2'b11, 1'b0, 1'b1, c, sl, d);
  endtask

  // ---------------------------------------------------------------- vector table
  typedef struct {
    logic [N_CH-1:0] en;
    logic            sync;
    logic [N_CH-1:0] exp_out;
    logic [N_CH-1:0] exp_tick;
  } vec_t;

  vec_t tbl[12];

  task automatic set_vec(input int idx, input logic [1:0] e, input logic s,
                         input logic [1:0] o, input logic [1:0] t);
    tbl[idx].en       = e;
    tbl[idx].sync     = s;
    tbl[idx].exp_out  = o;
    tbl[idx].exp_tick = t;
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------------------------------------------------------- test body
  int t0, t1, o0, o1;
  logic [1:0] pat_out;
  logic [1:0] pat_tick;
  logic       rr, ss, ww, sl;
  logic [1:0] ee;
  logic [2:0] cc;
  logic [7:0] dd;

  initial begin
    // First 12 cycles after reset release, both channels at 10/5.
    set_vec(0,  2'b11, 1'b0, 2'b11, 2'b00);
    set_vec(1,  2'b11, 1'b0, 2'b11, 2'b00);
    set_vec(2,  2'b11, 1'b0, 2'b11, 2'b00);
    set_vec(3,  2'b11, 1'b0, 2'b11, 2'b00);
    set_vec(4,  2'b11, 1'b0, 2'b11, 2'b00);
    set_vec(5,  2'b11, 1'b0, 2'b00, 2'b00);
    set_vec(6,  2'b11, 1'b0, 2'b00, 2'b00);
    set_vec(7,  2'b11, 1'b0, 2'b00, 2'b00);
    set_vec(8,  2'b11, 1'b0, 2'b00, 2'b00);
    set_vec(9,  2'b11, 1'b0, 2'b00, 2'b11);
    set_vec(10, 2'b11, 1'b0, 2'b11, 2'b00);
    set_vec(11, 2'b11, 1'b0, 2'b11, 2'b00);

    model_reset();

    // Reset state
    drive(1'b1, 2'b11, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0);
    drive(1'b1, 2'b11, 1'b1, 1'b1, 3'd0, 1'b0, 8'd3);
    check("reset_out_clk", out_clk, 2'b00);
    check("reset_tick", tick, 2'b00);

    // Default period/high after release
    for (int k = 0; k < 12; k++) begin
      drive(1'b0, tbl[k].en, tbl[k].sync, 1'b0, 3'd0, 1'b0, 8'd0);
      check("tbl_out_clk", out_clk, tbl[k].exp_out);
      check("tbl_tick", tick, tbl[k].exp_tick);
    end

    // ch0 per=3 written mid-period (cnt=4): current period finishes first
    idle();
    idle();
    wr(3'd0, 1'b0, 8'd3);
    for (int k = 0; k < 5; k++) idle();
    check("ch0_finish_wrap", tick, 2'b11);
    t0 = 0; t1 = 0; o0 = 0;
    for (int k = 0; k < 12; k++) begin
      idle();
      t0 += int'(tick[0]);
      t1 += int'(tick[1]);
      o0 += int'(out_clk[0]);
    end
    check("ch0_per4_ticks", t0, 3);
    check("ch1_unchanged_ticks", t1, 1);
    check("ch0_per4_const_high", o0, 12);

    // ch1 hi=0 written on its wrap cycle
    for (int k = 0; k < 7; k++) idle();
    wr(3'd1, 1'b1, 8'd0);
    check("ch1_wrap_tick", tick[1], 1'b1);
    o1 = 0;
    for (int k = 0; k < 10; k++) begin
      idle();
      o1 += int'(out_clk[1]);
    end
    check("ch1_old_hi_period", o1, 5);
    o1 = 0;
    for (int k = 0; k < 10; k++) begin
      idle();
      o1 += int'(out_clk[1]);
    end
    check("ch1_hi0_low", o1, 0);

    // Drift the channels apart, then sync them
    wr(3'd0, 1'b0, 8'd9);
    wr(3'd1, 1'b1, 8'd5);
    for (int k = 0; k < 3; k++) drive(1'b0, 2'b01, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0);
    for (int k = 0; k < 4; k++) idle();
    drive(1'b0, 2'b11, 1'b1, 1'b0, 3'd0, 1'b0, 8'd0);
    check("sync_no_tick", tick, 2'b00);
    for (int k = 1; k <= 20; k++) begin
      idle();
      pat_out  = (((k - 1) % 10) < 5) ? 2'b11 : 2'b00;
      pat_tick = (((k - 1) % 10) == 9) ? 2'b11 : 2'b00;
      check("sync_out_clk", out_clk, pat_out);
      check("sync_tick", tick, pat_tick);
    end

    // Reset at cnt=7 with a concurrent write that must be lost
    for (int k = 0; k < 7; k++) idle();
    drive(1'b1, 2'b11, 1'b0, 1'b1, 3'd0, 1'b0, 8'd2);
    check("midreset_out_clk", out_clk, 2'b00);
    check("midreset_tick", tick, 2'b00);
    for (int k = 1; k <= 12; k++) begin
      idle();
      pat_out  = (((k - 1) % 10) < 5) ? 2'b11 : 2'b00;
      pat_tick = (((k - 1) % 10) == 9) ? 2'b11 : 2'b00;
      check("postreset_out_clk", out_clk, pat_out);
      check("postreset_tick", tick, pat_tick);
    end

    // ch0 per=0/hi=1, plus an out-of-range channel write
    wr(3'd0, 1'b0, 8'd0);
    wr(3'd0, 1'b1, 8'd1);
    wr(3'd5, 1'b0, 8'd1);
    for (int k = 0; k < 5; k++) idle();
    check("per0_wrap_tick", tick, 2'b11);
    for (int k = 1; k <= 8; k++) begin
      idle();
      check("per0_tick", tick[0], 1'b1);
      check("per0_out_clk", out_clk[0], 1'b1);
      check("ch5_ignored_ch1_out", out_clk[1], ((k - 1) < 5) ? 1'b1 : 1'b0);
    end

    // Random phase against the model
    for (int k = 0; k < 400; k++) begin
      rr = ($urandom_range(0, 99) == 0);
      ee = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      ss = ($urandom_range(0, 19) == 0);
      ww = ($urandom_range(0, 4) == 0);
      cc = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
      sl = 1'($urandom_range(0, 1));
      dd = 8'($urandom_range(0, 12));
      drive(rr, ee, ss, ww, cc, sl, dd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
